// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with a registered output stage.
// Grant is fixed-select or round-robin and is held for a whole packet.
module stream_mux_rr #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_last,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_last,
    output logic [SEL_W-1:0]          out_ch,
    input  logic                      out_ready
);

    localparam logic [SEL_W:0]   CH_LIM  = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

    typedef enum logic {IDLE, LOCKED} lock_state_t;

    lock_state_t      state;
    logic [SEL_W-1:0] lock_ch;
    logic [SEL_W-1:0] ptr;

    logic             can_accept;
    logic             g_ok;
    logic [SEL_W-1:0] g;
    logic [SEL_W:0]   rr_res;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;
    logic [SEL_W-1:0] ptr_next;

    // First valid channel at or after p, wrapping; MSB of the result flags a hit.
    function automatic logic [SEL_W:0] rr_pick(input logic [CHANNELS-1:0] v,
                                               input logic [SEL_W-1:0]    p);
        logic             found;
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] ki;
        int               k;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            k  = (int'(p) + i) % CHANNELS;
            ki = k[SEL_W-1:0];
            if (!found && v[ki]) begin
                found = 1'b1;
                idx   = ki;
            end
        end
        return {found, idx};
    endfunction

    // Stage 0: grant candidate and handshake
    assign can_accept = !out_valid || out_ready;
    assign rr_res     = rr_pick(in_valid, ptr);

    always_comb begin
        g    = '0;
        g_ok = 1'b0;
        if (state == LOCKED) begin
            g    = lock_ch;
            g_ok = 1'b1;
        end else if (!mode) begin
            g    = sel;
            g_ok = ({1'b0, sel} < CH_LIM);
        end else begin
            g    = rr_res[SEL_W-1:0];
            g_ok = rr_res[SEL_W];
        end
    end

    always_comb begin
        in_ready = '0;
        sel_data = '0;
        sel_last = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (g == SEL_W'(k)) begin
                in_ready[k] = rst_n && g_ok && can_accept;
                sel_data    = in_data[k*WIDTH +: WIDTH];
                sel_last    = in_last[k];
            end
        end
    end

    assign xfer     = |(in_ready & in_valid);
    assign ptr_next = (g == LAST_CH) ? '0 : g + 1'b1;

    // Stage 1: output register, packet lock and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
            state     <= IDLE;
            lock_ch   <= '0;
            ptr       <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_last  <= sel_last;
                out_ch    <= g;
                if (sel_last) begin
                    state <= IDLE;
                    ptr   <= ptr_next;
                end else begin
                    state   <= LOCKED;
                    lock_ch <= g;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
